ls_mem_arbiter: RTL and testbench
=================================

Name: ls_mem_arbiter

Overview:
- Shares the single DPI load/store memory port between the instruction-fetch unit (read-only) and the LSU (read/write).
- Sits between IFU/LSU and the DPI memory port block.
- Runs one transaction at a time and fires exactly one memory access strobe per transaction, so each pmem_read/pmem_write call happens exactly once.
- Provides a configurable access delay for latency modelling, with valid/ready handshakes on both the request and response sides.

Parameters:
LATENCY, 2, number of wait cycles between request acceptance and the memory access cycle (legal range 0..255)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
ifu_req_valid  input  1  IFU read request valid
ifu_req_ready  output  1  IFU request accepted this cycle
ifu_addr  input  32  IFU read address
ifu_resp_valid  output  1  IFU read data valid
ifu_resp_ready  input  1  IFU accepts response
ifu_rdata  output  32  IFU read data
lsu_req_valid  input  1  LSU request valid
lsu_req_ready  output  1  LSU request accepted this cycle
lsu_wen  input  1  1 = store, 0 = load
lsu_addr  input  32  LSU address
lsu_wdata  input  32  store data
lsu_wmask  input  8  store byte mask
lsu_resp_valid  output  1  LSU response valid (load data or store done)
lsu_resp_ready  input  1  LSU accepts response
lsu_rdata  output  32  LSU load data; 0 for stores
mem_ld_en  output  1  memory load strobe
mem_st_en  output  1  memory store strobe
mem_raddr  output  32  memory read address
mem_rdata  input  32  memory read data, valid in the same cycle as mem_ld_en
mem_waddr  output  32  memory write address
mem_wdata  output  32  memory write data
mem_wmask  output  8  memory write mask

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; wait counter = 0.
  - Latched request and read data registers are cleared to 0.
  - Round-robin pointer is set to favour IFU.
  - All outputs are 0.
  - An in-flight transaction is discarded with no strobe and no response. If reset lands in ACCESS, the strobe drops immediately.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready is combinational: only the arbitration winner sees ready = 1, and only while its valid is high. ready is 0 in every other state.
  - Arbitration when one requester is valid: that requester wins.
  - Arbitration when both are valid: the pointer decides. After each grant the pointer flips to favour the other requester.
  - On acceptance, latch owner, wen, addr, wdata and wmask. IFU requests always latch wen = 0 and wmask = 0.
  - If LATENCY > 0: go to WAIT with counter = LATENCY-1. If LATENCY = 0: go to ACCESS.
- WAIT:
  - Counter decrements each cycle; at 0, go to ACCESS.
  - Requester inputs are ignored, so the latched values are used.
- ACCESS (exactly 1 cycle):
  - Load: mem_ld_en = 1, mem_raddr = latched addr; register mem_rdata at the clock edge.
  - Store: mem_st_en = 1 with mem_waddr, mem_wdata and mem_wmask driven from the latched values; registered read data = 0.
  - Go to RESP.
  - The mem_* address, data and mask outputs are 0 in every other state.
- RESP:
  - resp_valid = 1 to the owner only; rdata = registered data. The non-owner sees valid = 0 and rdata = 0.
  - Hold until the owner's resp_ready = 1, then go to IDLE.
  - Response data stays stable while stalled.
  - resp_ready arriving in the first RESP cycle completes the response that cycle.
- Timing: accept at edge T → strobe in cycle T+LATENCY+1 → resp_valid from cycle T+LATENCY+2.
- Throughput: one transaction per LATENCY+3 cycles minimum, because the next grant happens in IDLE after the response handshake.
- mem_ld_en and mem_st_en are never high together, and never high outside ACCESS.
- A request deasserting valid before being granted is simply not served; there is no ordering guarantee for withdrawn requests.
- Addresses are passed unmodified, with no alignment check.

Test Plan:
1. Reset mid-WAIT: LSU store to 0x80000010 accepted, reset asserted next cycle → mem_st_en never asserts, all outputs 0 asynchronously, IDLE after release.
2. IFU alone, LATENCY=2: ifu_addr=0x80000000, mem_rdata=0x00000413 → ifu_req_ready in cycle 0, mem_ld_en only in cycle 3 with mem_raddr=0x80000000, ifu_resp_valid from cycle 4 with ifu_rdata=0x00000413.
3. LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F → exactly one mem_st_en cycle with matching waddr/wdata/wmask, then lsu_resp_valid=1 with lsu_rdata=0.
4. Both valid continuously after reset → grants alternate IFU, LSU, IFU, LSU; each response goes only to its owner.
5. Response backpressure: LSU load returning 0x12345678 with lsu_resp_ready held low 5 cycles → lsu_resp_valid and data stable for 5 cycles, no second mem_ld_en, IDLE one cycle after ready.
6. LATENCY=0: IFU request → mem_ld_en in the cycle right after acceptance, resp_valid the following cycle.

Source files
------------

// File: rtl/ls_mem_arbiter.sv
// Arbitrates the single load/store memory port between IFU fetches and LSU accesses.
// One transaction in flight; exactly one memory strobe per transaction after LATENCY wait cycles.
module ls_mem_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic        mem_ld_en,
    output logic        mem_st_en,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask
);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

    localparam logic [7:0] WaitInit = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        prefer_lsu_q, prefer_lsu_d;
    logic        own_lsu_q, own_lsu_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [31:0] rdata_q, rdata_d;

    logic grant_ifu, grant_lsu, accept, owner_ready;

    // Single requester always wins; on contention the pointer picks.
    assign grant_lsu   = lsu_req_valid && (!ifu_req_valid || prefer_lsu_q);
    assign grant_ifu   = ifu_req_valid && (!lsu_req_valid || !prefer_lsu_q);
    assign accept      = (state_q == StIdle) && (grant_ifu || grant_lsu);
    assign owner_ready = own_lsu_q ? lsu_resp_ready : ifu_resp_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = (LATENCY > 0) ? StWait : StAccess;
            StWait:   if (cnt_q == 8'd0) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   if (owner_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        prefer_lsu_d = prefer_lsu_q;
        own_lsu_d    = own_lsu_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        rdata_d      = rdata_q;
        if (accept) begin
            cnt_d        = WaitInit;
            prefer_lsu_d = grant_ifu;
            own_lsu_d    = grant_lsu;
            wen_d        = grant_lsu && lsu_wen;
            addr_d       = grant_lsu ? lsu_addr : ifu_addr;
            wdata_d      = grant_lsu ? lsu_wdata : 32'd0;
            wmask_d      = grant_lsu ? lsu_wmask : 8'd0;
        end else if (state_q == StWait && cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end else if (state_q == StAccess) begin
            rdata_d = wen_q ? 32'd0 : mem_rdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= 8'd0;
            prefer_lsu_q <= 1'b0;
            own_lsu_q    <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wmask_q      <= 8'd0;
            rdata_q      <= 32'd0;
        end else begin
            cnt_q        <= cnt_d;
            prefer_lsu_q <= prefer_lsu_d;
            own_lsu_q    <= own_lsu_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = 32'd0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = 32'd0;
        mem_ld_en      = 1'b0;
        mem_st_en      = 1'b0;
        mem_raddr      = 32'd0;
        mem_waddr      = 32'd0;
        mem_wdata      = 32'd0;
        mem_wmask      = 8'd0;
        case (state_q)
            StIdle: begin
                // Gated by reset so outputs are 0 while reset is held.
                ifu_req_ready = grant_ifu && !reset;
                lsu_req_ready = grant_lsu && !reset;
            end
            StAccess: begin
                if (wen_q) begin
                    mem_st_en = 1'b1;
                    mem_waddr = addr_q;
                    mem_wdata = wdata_q;
                    mem_wmask = wmask_q;
                end else begin
                    mem_ld_en = 1'b1;
                    mem_raddr = addr_q;
                end
            end
            StResp: begin
                if (own_lsu_q) begin
                    lsu_resp_valid = 1'b1;
                    lsu_rdata      = rdata_q;
                end else begin
                    ifu_resp_valid = 1'b1;
                    ifu_rdata      = rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ls_mem_arbiter.sv
// Directed bench for ls_mem_arbiter: vector table for single/alternating transactions plus
// hand sequences for reset, backpressure and the zero-latency variant.
module tb_ls_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_resp_ready, lsu_req_valid, lsu_wen, lsu_resp_ready;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [7:0]  lsu_wmask;

    logic        ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid;
    logic        mem_ld_en, mem_st_en;
    logic [31:0] ifu_rdata, lsu_rdata, mem_raddr, mem_waddr, mem_wdata;
    logic [7:0]  mem_wmask;

    logic        z_ifu_req_ready, z_ifu_resp_valid, z_lsu_req_ready, z_lsu_resp_valid;
    logic        z_mem_ld_en, z_mem_st_en;
    logic [31:0] z_ifu_rdata, z_lsu_rdata, z_mem_raddr, z_mem_waddr, z_mem_wdata;
    logic [7:0]  z_mem_wmask;

    int checks = 0;
    int errors = 0;
    int ld_cnt = 0;
    int st_cnt = 0;

    always #5 clock = ~clock;

    ls_mem_arbiter #(.LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_ld_en(mem_ld_en), .mem_st_en(mem_st_en), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask)
    );

    ls_mem_arbiter #(.LATENCY(0)) dut0 (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(z_ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(z_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(z_ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(z_lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(z_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(z_lsu_rdata),
        .mem_ld_en(z_mem_ld_en), .mem_st_en(z_mem_st_en), .mem_raddr(z_mem_raddr),
        .mem_rdata(mem_rdata), .mem_waddr(z_mem_waddr), .mem_wdata(z_mem_wdata),
        .mem_wmask(z_mem_wmask)
    );

    always @(negedge clock) begin
        if (mem_ld_en) ld_cnt++;
        if (mem_st_en) st_cnt++;
    end

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        irr;
        logic        lv;
        logic        lw;
        logic [31:0] la;
        logic [31:0] lwd;
        logic [7:0]  lm;
        logic        lrr;
        logic [31:0] mrd;
        logic        e_irdy;
        logic        e_lrdy;
        logic        e_ld;
        logic        e_st;
        logic [31:0] e_maddr;
        logic [31:0] e_wdata;
        logic [7:0]  e_wmask;
        logic        e_irv;
        logic        e_lrv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic irdy, input logic lrdy,
                              input logic ld, input logic st, input logic [31:0] maddr,
                              input logic [31:0] wd, input logic [7:0] wm, input logic irv,
                              input logic lrv, input logic [31:0] rd);
        chk({tag, " ifu_req_ready"}, 32'(ifu_req_ready), 32'(irdy));
        chk({tag, " lsu_req_ready"}, 32'(lsu_req_ready), 32'(lrdy));
        chk({tag, " mem_ld_en"}, 32'(mem_ld_en), 32'(ld));
        chk({tag, " mem_st_en"}, 32'(mem_st_en), 32'(st));
        chk({tag, " mem_raddr"}, mem_raddr, ld ? maddr : 32'd0);
        chk({tag, " mem_waddr"}, mem_waddr, st ? maddr : 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, wd);
        chk({tag, " mem_wmask"}, 32'(mem_wmask), 32'(wm));
        chk({tag, " ifu_resp_valid"}, 32'(ifu_resp_valid), 32'(irv));
        chk({tag, " ifu_rdata"}, ifu_rdata, irv ? rd : 32'd0);
        chk({tag, " lsu_resp_valid"}, 32'(lsu_resp_valid), 32'(lrv));
        chk({tag, " lsu_rdata"}, lsu_rdata, lrv ? rd : 32'd0);
    endtask

    function automatic vec_t idle_row();
        vec_t v;
        v = '{default: 0};
        v.irr = 1'b1;
        v.lrr = 1'b1;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 1;
        lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        lsu_resp_ready = 1; mem_rdata = 0;
    endtask

    // Waits (bounded) for any dut response and accepts it.
    task automatic drain(input string tag);
        bit seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            next_cycle();
            clear_inputs();
            @(negedge clock);
            if (ifu_resp_valid || lsu_resp_valid) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s drain: got no response expected one within 12 cycles", tag);
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        vec_t v;
        int   ld0, st0;

        // Reset state
        reset = 1'b1;
        clear_inputs();
        #2;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        reset = 1'b0;

        // LATENCY=0 instance: strobe right after acceptance, response the cycle after
        next_cycle();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
        @(negedge clock);
        chk("lat0 ifu_req_ready", 32'(z_ifu_req_ready), 32'd1);
        next_cycle();
        ifu_req_valid = 0; mem_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        chk("lat0 mem_ld_en", 32'(z_mem_ld_en), 32'd1);
        chk("lat0 mem_raddr", z_mem_raddr, 32'h8000_0200);
        chk("lat0 ifu_resp_valid early", 32'(z_ifu_resp_valid), 32'd0);
        next_cycle();
        mem_rdata = 32'h0;
        @(negedge clock);
        chk("lat0 ifu_resp_valid", 32'(z_ifu_resp_valid), 32'd1);
        chk("lat0 ifu_rdata", z_ifu_rdata, 32'hCAFE_F00D);
        chk("lat0 mem_ld_en after", 32'(z_mem_ld_en), 32'd0);
        next_cycle();
        next_cycle();
        next_cycle();  // LATENCY=2 instance finishes the same fetch here

        // IFU alone, LATENCY=2
        v = idle_row(); v.iv = 1; v.ia = 32'h8000_0000; v.e_irdy = 1; tbl.push_back(v);
        v = idle_row(); tbl.push_back(v);
        v = idle_row(); tbl.push_back(v);
        v = idle_row(); v.mrd = 32'h0000_0413; v.e_ld = 1; v.e_maddr = 32'h8000_0000;
        tbl.push_back(v);
        v = idle_row(); v.e_irv = 1; v.e_rdata = 32'h0000_0413; tbl.push_back(v);
        // LSU store
        v = idle_row(); v.lv = 1; v.lw = 1; v.la = 32'h8000_1000; v.lwd = 32'hDEAD_BEEF;
        v.lm = 8'h0F; v.e_lrdy = 1; tbl.push_back(v);
        v = idle_row(); tbl.push_back(v);
        v = idle_row(); tbl.push_back(v);
        v = idle_row(); v.e_st = 1; v.e_maddr = 32'h8000_1000; v.e_wdata = 32'hDEAD_BEEF;
        v.e_wmask = 8'h0F; tbl.push_back(v);
        v = idle_row(); v.e_lrv = 1; v.e_rdata = 32'h0; tbl.push_back(v);
        // Both valid continuously: IFU, LSU, IFU, LSU
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 5; p++) begin
                v = idle_row();
                v.iv = 1; v.ia = 32'h8000_0100; v.lv = 1; v.la = 32'h8000_2000;
                if (p == 0) begin
                    v.e_irdy = (k % 2 == 0);
                    v.e_lrdy = (k % 2 == 1);
                end
                if (p == 3) begin
                    v.mrd = 32'h1111_1111 * (k + 1);
                    v.e_ld = 1;
                    v.e_maddr = (k % 2 == 0) ? 32'h8000_0100 : 32'h8000_2000;
                end
                if (p == 4) begin
                    v.e_irv = (k % 2 == 0);
                    v.e_lrv = (k % 2 == 1);
                    v.e_rdata = 32'h1111_1111 * (k + 1);
                end
                tbl.push_back(v);
            end
        end

        foreach (tbl[i]) begin
            next_cycle();
            ifu_req_valid = tbl[i].iv; ifu_addr = tbl[i].ia; ifu_resp_ready = tbl[i].irr;
            lsu_req_valid = tbl[i].lv; lsu_wen = tbl[i].lw; lsu_addr = tbl[i].la;
            lsu_wdata = tbl[i].lwd; lsu_wmask = tbl[i].lm; lsu_resp_ready = tbl[i].lrr;
            mem_rdata = tbl[i].mrd;
            @(negedge clock);
            check_outs($sformatf("row%0d", i), tbl[i].e_irdy, tbl[i].e_lrdy, tbl[i].e_ld,
                       tbl[i].e_st, tbl[i].e_maddr, tbl[i].e_wdata, tbl[i].e_wmask,
                       tbl[i].e_irv, tbl[i].e_lrv, tbl[i].e_rdata);
        end
        next_cycle();
        clear_inputs();

        // Response backpressure on an LSU load
        next_cycle();
        lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_resp_ready = 0;
        @(negedge clock);
        chk("bp lsu_req_ready", 32'(lsu_req_ready), 32'd1);
        ld0 = ld_cnt;
        next_cycle();
        lsu_req_valid = 0;
        next_cycle();
        next_cycle();
        mem_rdata = 32'h1234_5678;
        @(negedge clock);
        chk("bp mem_ld_en", 32'(mem_ld_en), 32'd1);
        chk("bp mem_raddr", mem_raddr, 32'h8000_3000);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            mem_rdata = $urandom;
            @(negedge clock);
            chk($sformatf("bp stall%0d lsu_resp_valid", i), 32'(lsu_resp_valid), 32'd1);
            chk($sformatf("bp stall%0d lsu_rdata", i), lsu_rdata, 32'h1234_5678);
        end
        next_cycle();
        lsu_resp_ready = 1;
        @(negedge clock);
        chk("bp handshake lsu_resp_valid", 32'(lsu_resp_valid), 32'd1);
        chk("bp handshake lsu_rdata", lsu_rdata, 32'h1234_5678);
        next_cycle();
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_4000;
        @(negedge clock);
        chk("bp idle lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
        chk("bp idle lsu_req_ready", 32'(lsu_req_ready), 32'd1);
        chk("bp single load strobe", 32'(ld_cnt - ld0), 32'd1);
        drain("bp");

        // Reset while waiting on an accepted store
        next_cycle();
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_0010;
        lsu_wdata = 32'hA5A5_A5A5; lsu_wmask = 8'hFF;
        @(negedge clock);
        chk("rst lsu_req_ready", 32'(lsu_req_ready), 32'd1);
        st0 = st_cnt;
        next_cycle();
        reset = 1'b1;
        #1;
        check_outs("rst async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        lsu_req_valid = 0;
        for (int i = 0; i < 6; i++) next_cycle();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0300;
        @(negedge clock);
        chk("rst no store strobe", 32'(st_cnt - st0), 32'd0);
        chk("rst idle ifu_req_ready", 32'(ifu_req_ready), 32'd1);
        chk("rst idle lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
        drain("rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
